// File: rtl/alu_exec_pkg.sv
// Shared constants for the registered execute-stage slice: aluop classes, ALU op codes, funct codes.
// Shift op codes are only emitted by the decoder when ALU_SHIFT_EN is defined.
package alu_exec_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_NAND  = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_PASSB = 3'b111;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_NAND  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_PASSB = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_AND = 4'b0100;
    localparam logic [3:0] FUNCT_OR  = 4'b0101;
    localparam logic [3:0] FUNCT_XOR = 4'b0110;
    localparam logic [3:0] FUNCT_NOR = 4'b0111;
    localparam logic [3:0] FUNCT_SLL = 4'b1000;
    localparam logic [3:0] FUNCT_SRL = 4'b1001;
    localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/alu_exec_decode.sv
// ALU-control decoder: maps the main-control aluop class and funct low bits to a 4-bit ALU op.
// Optional macro ALU_SHIFT_EN adds the sll/srl funct decodes.
module alu_exec_decode
    import alu_exec_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [3:0] funct,
    output logic [3:0] gout
);

    always_comb begin
        gout = OP_ADD;
        case (aluop)
            ALUOP_ADD:   gout = OP_ADD;
            ALUOP_SUB:   gout = OP_SUB;
            ALUOP_OR:    gout = OP_OR;
            ALUOP_AND:   gout = OP_AND;
            ALUOP_NAND:  gout = OP_NAND;
            ALUOP_SLT:   gout = OP_SLT;
            ALUOP_PASSB: gout = OP_PASSB;
            ALUOP_RTYPE: begin
                // Unlisted funct codes fall back to add
                case (funct)
                    FUNCT_SUB: gout = OP_SUB;
                    FUNCT_AND: gout = OP_AND;
                    FUNCT_OR:  gout = OP_OR;
                    FUNCT_XOR: gout = OP_XOR;
                    FUNCT_NOR: gout = OP_NOR;
                    FUNCT_SLT: gout = OP_SLT;
`ifdef ALU_SHIFT_EN
                    FUNCT_SLL: gout = OP_SLL;
                    FUNCT_SRL: gout = OP_SRL;
`endif
                    default:   gout = OP_ADD;
                endcase
            end
            default:     gout = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: ALU-control decode, 32-bit ALU with flags and a free address adder,
// all captured in one output register with a valid bit. Macro ALU_SHIFT_EN enables sll/srl.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic             out_valid,
    output logic [3:0]       gout,
    output logic [WIDTH-1:0] sum,
    output logic             zout,
    output logic             zflag,
    output logic             nflag,
    output logic             vflag,
    output logic [WIDTH-1:0] add_sum
);

    logic [3:0]       op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_v;

    logic             out_valid_d, out_valid_q;
    logic [3:0]       gout_d, gout_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             zout_d, zout_q;
    logic             nflag_d, nflag_q;
    logic             vflag_d, vflag_q;
    logic [WIDTH-1:0] add_sum_d, add_sum_q;

    alu_exec_decode u_decode (
        .aluop (aluop),
        .funct (funct),
        .gout  (op)
    );

    always_comb begin
        alu_result = '0;
        alu_v      = 1'b0;
        case (op)
            OP_AND:   alu_result = a & b;
            OP_OR:    alu_result = a | b;
            OP_XOR:   alu_result = a ^ b;
            OP_NOR:   alu_result = ~(a | b);
            OP_NAND:  alu_result = ~(a & b);
            OP_PASSB: alu_result = b;
            OP_ADD: begin
                alu_result = a + b;
                alu_v      = (a[WIDTH-1] == b[WIDTH-1]) && (alu_result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = a - b;
                alu_v      = (a[WIDTH-1] != b[WIDTH-1]) && (alu_result[WIDTH-1] != a[WIDTH-1]);
            end
            // Real signed compare, so it stays correct when a-b would overflow
            OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SHIFT_EN
            OP_SLL:   alu_result = a << b[4:0];
            OP_SRL:   alu_result = a >> b[4:0];
`endif
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        out_valid_d = in_valid;
        gout_d      = in_valid ? op : gout_q;
        sum_d       = in_valid ? alu_result : sum_q;
        zout_d      = in_valid ? (alu_result == '0) : zout_q;
        nflag_d     = in_valid ? alu_result[WIDTH-1] : nflag_q;
        vflag_d     = in_valid ? alu_v : vflag_q;
        add_sum_d   = in_valid ? (add_a + add_b) : add_sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            gout_q      <= '0;
            sum_q       <= '0;
            zout_q      <= 1'b0;
            nflag_q     <= 1'b0;
            vflag_q     <= 1'b0;
            add_sum_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            gout_q      <= gout_d;
            sum_q       <= sum_d;
            zout_q      <= zout_d;
            nflag_q     <= nflag_d;
            vflag_q     <= vflag_d;
            add_sum_q   <= add_sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign gout      = gout_q;
    assign sum       = sum_q;
    assign zout      = zout_q;
    assign zflag     = zout_q;
    assign nflag     = nflag_q;
    assign vflag     = vflag_q;
    assign add_sum   = add_sum_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expected values.
// Shift vectors follow ALU_SHIFT_EN exactly as the design does.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a, b, add_a, add_b;
    logic        out_valid;
    logic [3:0]  gout;
    logic [31:0] sum;
    logic        zout, zflag, nflag, vflag;
    logic [31:0] add_sum;

    int vectorCount = 0;
    int missCount   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .aluop     (aluop),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .add_a     (add_a),
        .add_b     (add_b),
        .out_valid (out_valid),
        .gout      (gout),
        .sum       (sum),
        .zout      (zout),
        .zflag     (zflag),
        .nflag     (nflag),
        .vflag     (vflag),
        .add_sum   (add_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs away from the rising edge, then sample 1ns after the capturing edge
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [3:0] fn,
                                 input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [31:0] aa, input logic [31:0] ab);
        @(negedge clk);
        in_valid = v;
        aluop    = op;
        funct    = fn;
        a        = ia;
        b        = ib;
        add_a    = aa;
        add_b    = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
        end
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] eg, input logic [31:0] es,
                              input logic ez, input logic en, input logic ev);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, ".gout"},  {28'd0, gout},      {28'd0, eg});
        checkOutput({tag, ".sum"},   sum,                es);
        checkOutput({tag, ".zout"},  {31'd0, zout},      {31'd0, ez});
        checkOutput({tag, ".zflag"}, {31'd0, zflag},     {31'd0, ez});
        checkOutput({tag, ".nflag"}, {31'd0, nflag},     {31'd0, en});
        checkOutput({tag, ".vflag"}, {31'd0, vflag},     {31'd0, ev});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        aluop    = 3'b000;
        funct    = 4'b0000;
        a        = '0;
        b        = '0;
        add_a    = '0;
        add_b    = '0;
        #12;
        checkOutput("reset.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset.sum",   sum,                32'd0);
        checkOutput("reset.addsum", add_sum,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 3'b000, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'd0, 32'd0);
        checkFlags("add_ovf", 4'b0010, 32'h80000000, 1'b0, 1'b1, 1'b1);

        applyStimulus(1'b1, 3'b001, 4'b0000, 32'h12345678, 32'h12345678, 32'd0, 32'd0);
        checkFlags("sub_zero", 4'b0110, 32'h00000000, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 3'b001, 4'b0000, 32'h80000000, 32'h00000001, 32'd0, 32'd0);
        checkFlags("sub_ovf", 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 3'b010, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0);
        checkFlags("r_and", 4'b0000, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0);
        checkFlags("r_or", 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0);
        checkFlags("r_xor", 4'b0011, 32'hFF00FF00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0);
        checkFlags("r_nor", 4'b0100, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b1010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0);
        checkFlags("r_slt", 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b1111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0);
        checkFlags("r_dflt", 4'b0010, 32'h00E100E0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b0010, 32'h00000003, 32'h00000005, 32'd0, 32'd0);
        checkFlags("r_sub", 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);

        // slt where a-b overflows: the sign of the difference would give the wrong answer
        applyStimulus(1'b1, 3'b110, 4'b0000, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0);
        checkFlags("slt_wrap", 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b110, 4'b0000, 32'h00000005, 32'hFFFFFFFD, 32'd0, 32'd0);
        checkFlags("slt_false", 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 3'b101, 4'b0000, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 32'd0);
        checkFlags("nand", 4'b0101, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b111, 4'b0000, 32'h11111111, 32'hDEADBEEF, 32'd0, 32'd0);
        checkFlags("passb", 4'b1000, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);

        applyStimulus(1'b0, 3'b000, 4'b0000, 32'h00000001, 32'h00000001, 32'h5, 32'h5);
        checkOutput("hold.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("hold.sum",   sum,                32'hDEADBEEF);
        checkOutput("hold.gout",  {28'd0, gout},      32'h00000008);
        checkOutput("hold.nflag", {31'd0, nflag},     32'd1);
        checkOutput("hold.addsum", add_sum,           32'h00000000);

        applyStimulus(1'b1, 3'b011, 4'b0000, 32'h00000F00, 32'h000000F0, 32'h00400000, 32'h00000004);
        checkFlags("or_imm", 4'b0001, 32'h00000FF0, 1'b0, 1'b0, 1'b0);
        checkOutput("adder", add_sum, 32'h00400004);
        applyStimulus(1'b1, 3'b100, 4'b0000, 32'h0000FFFF, 32'h00FF00FF, 32'hFFFFFFFC, 32'h00000008);
        checkFlags("and_imm", 4'b0000, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        checkOutput("adder_wrap", add_sum, 32'h00000004);

`ifdef ALU_SHIFT_EN
        applyStimulus(1'b1, 3'b010, 4'b1000, 32'h00000001, 32'd31, 32'd0, 32'd0);
        checkFlags("sll", 4'b1001, 32'h80000000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b1001, 32'h80000000, 32'd31, 32'd0, 32'd0);
        checkFlags("srl", 4'b1010, 32'h00000001, 1'b0, 1'b0, 1'b0);
`else
        applyStimulus(1'b1, 3'b010, 4'b1000, 32'h00000001, 32'd31, 32'd0, 32'd0);
        checkFlags("sll_off", 4'b0010, 32'h00000020, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 4'b1001, 32'h80000000, 32'd31, 32'd0, 32'd0);
        checkFlags("srl_off", 4'b0010, 32'h8000001F, 1'b0, 1'b1, 1'b0);
`endif

        // Asynchronous reset between edges while out_valid is high
        applyStimulus(1'b1, 3'b000, 4'b0000, 32'h00000010, 32'h00000020, 32'h00000100, 32'h00000200);
        checkFlags("pre_rst", 4'b0010, 32'h00000030, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.valid",  {31'd0, out_valid}, 32'd0);
        checkOutput("rst.sum",    sum,                32'd0);
        checkOutput("rst.gout",   {28'd0, gout},      32'd0);
        checkOutput("rst.addsum", add_sum,            32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst.held",   {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'b001, 4'b0000, 32'h00000005, 32'h00000007, 32'd1, 32'd2);
        checkFlags("post_rst", 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
        checkOutput("post_rst.addsum", add_sum, 32'h00000003);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute-stage slice of the single-cycle MIPS-style datapath.
- Bundles three functions: the ALU-control decoder (aluop plus funct low bits to a 4-bit ALU op), the 32-bit ALU with flags, and a free 32-bit address adder (PC+4 or branch-target path).
- All results are captured in one output register stage with a valid bit.

Parameters:
- WIDTH, 32, datapath width of ALU operands, result and adder. Only 32 is required to be supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/controls valid this cycle
- aluop  in  3  ALU operation class from main control
- funct  in  4  instruction bits [3:0], used when aluop=010
- a  in  32  ALU operand A (register read data 1)
- b  in  32  ALU operand B (mux-selected register or immediate)
- add_a  in  32  adder operand A
- add_b  in  32  adder operand B
- out_valid  out  1  registered in_valid
- gout  out  4  registered decoded ALU op
- sum  out  32  registered ALU result
- zout  out  1  registered, sum==0
- zflag  out  1  registered, identical to zout
- nflag  out  1  registered, sum[31]
- vflag  out  1  registered signed overflow
- add_sum  out  32  registered add_a+add_b

Behaviour:
- Reset: rst_n low clears all outputs to 0 immediately (async), including out_valid. Release is sampled on the next rising clk edge.
- Latency: exactly 1 cycle. Values presented at edge N appear on the outputs after edge N.
- Output register update:
  - in_valid=1: all outputs load the new values.
  - in_valid=0: out_valid loads 0; all other outputs hold their previous values.
- No backpressure.
- Decode, aluop to gout:
  - 000 add (0010)
  - 001 sub (0110)
  - 010 R-type, see funct table below
  - 011 or (0001)
  - 100 and (0000)
  - 101 nand (0101)
  - 110 slt (0111)
  - 111 passB (1000)
- R-type, funct to gout:
  - 0000 add
  - 0010 sub
  - 0100 and
  - 0101 or
  - 0110 xor (0011)
  - 0111 nor (0100)
  - 1010 slt
  - any other funct decodes to add
- ALU operations:
  - and/or/xor/nor/nand: bitwise.
  - add/sub: modulo 2^32.
  - slt: true signed compare of a<b (not the sign of the difference); result 32'd1 or 32'd0.
  - passB: result = b.
  - Unused gout codes: result 0.
- vflag:
  - add: a[31]==b[31] and result[31]!=a[31].
  - sub: a[31]!=b[31] and result[31]!=a[31].
  - All other ops: 0.
- zout, zflag and nflag are derived from the final result for every op.
- add_sum is add_a+add_b modulo 2^32; carry discarded. It is independent of the ALU path.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: funct 1000 gives sll (gout 1001), sum = a << b[4:0]; funct 1001 gives srl (gout 1010), sum = a >> b[4:0], logical. vflag=0 for both.
- Undefined: funct 1000 and 1001 decode to add like any other unlisted funct, and gout codes 1001/1010 are never produced.

Decomposition:
- Package alu_exec_pkg: aluop class constants, the gout op-code localparams (AND, OR, ADD, XOR, NOR, NAND, SUB, SLT, PASSB, SLL, SRL), and the funct code constants.
- One natural combinational sub-module: alu_exec_decode (aluop, funct to gout).
- ALU, flags, adder and output register live in the top.

Test Plan:
- Reset mid-operation: assert rst_n=0 between edges while out_valid=1 -> all outputs 0 immediately. First valid input after release appears one edge later.
- Add overflow: aluop=000, a=7FFFFFFF, b=00000001 -> sum=80000000, vflag=1, nflag=1, zout=0, gout=0010.
- Sub to zero: aluop=001, a=b=12345678 -> sum=0, zout=zflag=1, vflag=0. Also a=80000000, b=1 -> sum=7FFFFFFF, vflag=1.
- R-type sweep with a=F0F0F0F0, b=0FF00FF0:
  - funct 0100 (and) -> 00F000F0
  - 0101 (or) -> FFF0FFF0
  - 0110 (xor) -> FF00FF00
  - 0111 (nor) -> 000F000F
  - 1010 (slt) -> 00000001 (negative a < positive b)
  - 1111 -> add result 00E10 0E0 with the spaces removed, i.e. 00E100E0
- Immediate classes: aluop=101 nand with a=FFFF0000, b=0000FFFF -> FFFFFFFF. aluop=111 -> sum=b. Hold check: in_valid=0 keeps sum and drops out_valid.
- Adder and shifts: add_a=00400000, add_b=4 -> add_sum=00400004, concurrent with an unrelated ALU op. With ALU_SHIFT_EN defined, funct 1000, a=1, b=31 -> 80000000; without the macro the same input -> 00000020 (add).
